// File: rtl/lif_step_scheduler.sv
// Timestep tick generator and two-neuron scheduler for the shared LIF update datapath.
// Owns both membranes, the refractory counters and the per-neuron configuration.
module lif_step_scheduler #(
    parameter int TICK_DIV = 16,
    parameter int REFR_W   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] in_cur0,
    input  logic [7:0] in_cur1,
    input  logic       cfg_we,
    input  logic [2:0] cfg_addr,
    input  logic [7:0] cfg_data,
    output logic       dp_req,
    output logic       dp_sel,
    output logic [7:0] dp_v,
    output logic [7:0] dp_cur,
    output logic [7:0] dp_thr,
    output logic [2:0] dp_leak,
    input  logic       dp_ack,
    input  logic [7:0] dp_v_in,
    input  logic       dp_spike,
    output logic [7:0] v0,
    output logic [7:0] v1,
    output logic       spike0,
    output logic       spike1,
    output logic       busy,
    output logic       overrun
);

    typedef enum logic [1:0] {IDLE, N0, N1} state_t;

    localparam logic [15:0]       TICK_LAST = 16'(TICK_DIV - 1);
    localparam logic [REFR_W-1:0] REFR_RST  = REFR_W'(3);
    localparam logic [REFR_W-1:0] REFR_ONE  = REFR_W'(1);

    logic [15:0]       cnt_q, cnt_d;
    logic              tick;
    logic              clr;
    logic              ack;
    state_t            state_q;

    logic [7:0]        thr0_q, thr1_q;
    logic [2:0]        leak0_q, leak1_q;
    logic [REFR_W-1:0] refr0_q, refr1_q;
    logic [REFR_W-1:0] rcnt0_q, rcnt1_q;
    logic [7:0]        v0_q, v1_q;

    logic              dp_req_q, dp_sel_q;
    logic [7:0]        dp_v_q, dp_cur_q, dp_thr_q;
    logic [2:0]        dp_leak_q;
    logic              spike0_q, spike1_q, ovr_q;

    // Timestep counter: free-runs while enabled, independent of the FSM
    always_comb begin
        cnt_d = cnt_q;
        if (ena) begin
            cnt_d = (cnt_q == TICK_LAST) ? 16'd0 : cnt_q + 16'd1;
        end
    end

    assign tick = ena && (cnt_q == TICK_LAST);
    assign clr  = cfg_we && (cfg_addr == 3'd6) && cfg_data[0];
    assign ack  = dp_req_q && dp_ack;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Configuration registers; cfg_data[REFR_W-1:0] assumes REFR_W <= 8
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            thr0_q  <= 8'd100;
            thr1_q  <= 8'd100;
            leak0_q <= 3'd2;
            leak1_q <= 3'd2;
            refr0_q <= REFR_RST;
            refr1_q <= REFR_RST;
        end else if (cfg_we) begin
            case (cfg_addr)
                3'd0:    thr0_q  <= cfg_data;
                3'd1:    thr1_q  <= cfg_data;
                3'd2:    leak0_q <= cfg_data[2:0];
                3'd3:    leak1_q <= cfg_data[2:0];
                3'd4:    refr0_q <= cfg_data[REFR_W-1:0];
                3'd5:    refr1_q <= cfg_data[REFR_W-1:0];
                default: ;
            endcase
        end
    end

    // Scheduler FSM; clear is applied first so a completing ack still wins on v
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            dp_req_q  <= 1'b0;
            dp_sel_q  <= 1'b0;
            dp_v_q    <= 8'd0;
            dp_cur_q  <= 8'd0;
            dp_thr_q  <= 8'd0;
            dp_leak_q <= 3'd0;
            v0_q      <= 8'd0;
            v1_q      <= 8'd0;
            rcnt0_q   <= '0;
            rcnt1_q   <= '0;
            spike0_q  <= 1'b0;
            spike1_q  <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            spike0_q <= 1'b0;
            spike1_q <= 1'b0;

            if (clr) begin
                v0_q    <= 8'd0;
                v1_q    <= 8'd0;
                rcnt0_q <= '0;
                rcnt1_q <= '0;
                ovr_q   <= 1'b0;
            end

            if (tick && (state_q != IDLE)) begin
                ovr_q <= 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (tick) begin
                        state_q <= N0;
                        if (rcnt0_q != '0) begin
                            dp_req_q <= 1'b0;
                            v0_q     <= 8'd0;
                            rcnt0_q  <= clr ? '0 : rcnt0_q - REFR_ONE;
                        end else begin
                            dp_req_q  <= 1'b1;
                            dp_sel_q  <= 1'b0;
                            dp_v_q    <= v0_q;
                            dp_cur_q  <= in_cur0;
                            dp_thr_q  <= thr0_q;
                            dp_leak_q <= leak0_q;
                        end
                    end
                end

                N0: begin
                    if (ack) begin
                        if (dp_spike) begin
                            v0_q     <= 8'd0;
                            rcnt0_q  <= refr0_q;
                            spike0_q <= 1'b1;
                        end else begin
                            v0_q <= dp_v_in;
                        end
                    end
                    // No request outstanding means this was a one-cycle refractory skip
                    if (ack || !dp_req_q) begin
                        state_q <= N1;
                        if (rcnt1_q != '0) begin
                            dp_req_q <= 1'b0;
                            v1_q     <= 8'd0;
                            rcnt1_q  <= clr ? '0 : rcnt1_q - REFR_ONE;
                        end else begin
                            dp_req_q  <= 1'b1;
                            dp_sel_q  <= 1'b1;
                            dp_v_q    <= v1_q;
                            dp_cur_q  <= in_cur1;
                            dp_thr_q  <= thr1_q;
                            dp_leak_q <= leak1_q;
                        end
                    end
                end

                N1: begin
                    if (ack) begin
                        if (dp_spike) begin
                            v1_q     <= 8'd0;
                            rcnt1_q  <= refr1_q;
                            spike1_q <= 1'b1;
                        end else begin
                            v1_q <= dp_v_in;
                        end
                    end
                    if (ack || !dp_req_q) begin
                        state_q  <= IDLE;
                        dp_req_q <= 1'b0;
                    end
                end

                default: begin
                    state_q  <= IDLE;
                    dp_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign dp_req  = dp_req_q;
    assign dp_sel  = dp_sel_q;
    assign dp_v    = dp_v_q;
    assign dp_cur  = dp_cur_q;
    assign dp_thr  = dp_thr_q;
    assign dp_leak = dp_leak_q;
    assign v0      = v0_q;
    assign v1      = v1_q;
    assign spike0  = spike0_q;
    assign spike1  = spike1_q;
    assign busy    = (state_q != IDLE);
    assign overrun = ovr_q;

endmodule

// File: tb/tb_lif_step_scheduler.sv
// Directed bench for lif_step_scheduler: two instances (TICK_DIV 8 and 16), each served
// by a behavioural LIF datapath with programmable acknowledge delay.
module tb_lif_step_scheduler;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] in_cur0, in_cur1;
    logic       cfg_we;
    logic [2:0] cfg_addr;
    logic [7:0] cfg_data;

    logic       dp_req[2], dp_sel[2], dp_ack[2], dp_spike[2];
    logic [7:0] dp_v[2], dp_cur[2], dp_thr[2], dp_v_in[2];
    logic [2:0] dp_leak[2];
    logic [7:0] v0[2], v1[2];
    logic       spike0[2], spike1[2], busy[2], overrun[2];
    logic [8:0] sum[2];
    int         ack_dly[2];
    int         wait_cnt[2];

    int n_chk  = 0;
    int n_fail = 0;
    int n;

    int exp_v0[10]   = '{30, 53, 70, 83, 93, 0, 0, 0, 0, 30};
    int exp_req0[10] = '{1, 1, 1, 1, 1, 1, 0, 0, 0, 1};
    int exp_v1[10]   = '{10, 18, 24, 28, 31, 34, 36, 37, 38, 39};

    always #5 clk = ~clk;

    lif_step_scheduler #(.TICK_DIV(8), .REFR_W(4)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .in_cur0(in_cur0), .in_cur1(in_cur1),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .dp_req(dp_req[0]), .dp_sel(dp_sel[0]), .dp_v(dp_v[0]), .dp_cur(dp_cur[0]),
        .dp_thr(dp_thr[0]), .dp_leak(dp_leak[0]), .dp_ack(dp_ack[0]),
        .dp_v_in(dp_v_in[0]), .dp_spike(dp_spike[0]), .v0(v0[0]), .v1(v1[0]),
        .spike0(spike0[0]), .spike1(spike1[0]), .busy(busy[0]), .overrun(overrun[0])
    );

    lif_step_scheduler #(.TICK_DIV(16), .REFR_W(4)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .in_cur0(in_cur0), .in_cur1(in_cur1),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .dp_req(dp_req[1]), .dp_sel(dp_sel[1]), .dp_v(dp_v[1]), .dp_cur(dp_cur[1]),
        .dp_thr(dp_thr[1]), .dp_leak(dp_leak[1]), .dp_ack(dp_ack[1]),
        .dp_v_in(dp_v_in[1]), .dp_spike(dp_spike[1]), .v0(v0[1]), .v1(v1[1]),
        .spike0(spike0[1]), .spike1(spike1[1]), .busy(busy[1]), .overrun(overrun[1])
    );

    // Behavioural datapath: v' = v - (v >> leak) + cur, spike when v' >= thr
    always_comb begin
        for (int k = 0; k < 2; k++) begin
            sum[k]      = {1'b0, dp_v[k]} - {1'b0, (dp_v[k] >> dp_leak[k])} + {1'b0, dp_cur[k]};
            dp_v_in[k]  = sum[k][8] ? 8'hFF : sum[k][7:0];
            dp_spike[k] = (sum[k] >= {1'b0, dp_thr[k]});
            dp_ack[k]   = dp_req[k] && (wait_cnt[k] >= ack_dly[k]);
        end
    end

    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n || !dp_req[k] || dp_ack[k]) wait_cnt[k] <= 0;
            else                                   wait_cnt[k] <= wait_cnt[k] + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic wait_busy(input int k, input int lim, output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!busy[k] && cyc < lim);
        check("busy_seen", busy[k], 1);
    endtask

    task automatic wait_idle(input int k, input int lim, output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (busy[k] && cyc < lim);
        check("idle_seen", busy[k], 0);
    endtask

    task automatic cfg_write(input logic [2:0] a, input logic [7:0] d);
        cfg_we   = 1'b1;
        cfg_addr = a;
        cfg_data = d;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        rst_n    = 1'b0;
        ena      = 1'b0;
        in_cur0  = 8'd30;
        in_cur1  = 8'd10;
        cfg_we   = 1'b0;
        cfg_addr = 3'd0;
        cfg_data = 8'd0;
        ack_dly[0] = 0;
        ack_dly[1] = 0;
        repeat (3) @(negedge clk);

        check("rst_req",   dp_req[0], 0);
        check("rst_busy",  busy[0], 0);
        check("rst_v0",    v0[0], 0);
        check("rst_ovr",   overrun[0], 0);
        check("rst_spk0",  spike0[0], 0);
        check("rst_dpthr", dp_thr[0], 0);
        check("rst_busy16", busy[1], 0);

        // Integrate to spike, then refractory, TICK_DIV=8, same-cycle ack
        rst_n = 1'b1;
        ena   = 1'b1;
        for (int t = 1; t <= 10; t++) begin
            wait_busy(0, 20, n);
            check($sformatf("tick_gap_t%0d", t), n, (t == 1) ? 8 : 6);
            check($sformatf("req0_t%0d", t), dp_req[0] && !dp_sel[0], exp_req0[t-1]);
            @(negedge clk);
            check($sformatf("v0_t%0d", t), v0[0], exp_v0[t-1]);
            check($sformatf("spk0_t%0d", t), spike0[0], (t == 6));
            check($sformatf("req1_t%0d", t), dp_req[0] && dp_sel[0], 1);
            @(negedge clk);
            check($sformatf("v1_t%0d", t), v1[0], exp_v1[t-1]);
            check($sformatf("spk0_end_t%0d", t), spike0[0], 0);
            check($sformatf("idle_t%0d", t), busy[0], 0);
        end

        // Slow datapath on the TICK_DIV=16 instance, ack 3 cycles after request
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        ack_dly[1] = 3;
        rst_n = 1'b1;
        wait_busy(1, 40, n);
        check("tick16_lat", n, 16);
        check("slow_req", dp_req[1], 1);
        check("slow_v",   dp_v[1], 0);
        check("slow_cur", dp_cur[1], 30);
        check("slow_thr", dp_thr[1], 100);
        check("slow_leak", dp_leak[1], 2);
        @(negedge clk);
        in_cur0 = 8'd99;
        cfg_write(3'd0, 8'd50);
        @(negedge clk);
        cfg_we = 1'b0;
        check("hold_cur_a", dp_cur[1], 30);
        check("hold_thr_a", dp_thr[1], 100);
        check("hold_req_a", dp_req[1], 1);
        @(negedge clk);
        check("hold_cur_b", dp_cur[1], 30);
        check("hold_thr_b", dp_thr[1], 100);
        check("hold_sel_b", dp_sel[1], 0);
        @(negedge clk);
        check("slow_n1_sel", dp_sel[1], 1);
        check("slow_n1_req", dp_req[1], 1);
        check("slow_v0",     v0[1], 30);
        check("slow_n1_cur", dp_cur[1], 10);
        repeat (3) @(negedge clk);
        check("slow_ack_req", dp_req[1], 1);
        @(negedge clk);
        check("slow_req_drop", dp_req[1], 0);
        check("slow_v1",       v1[1], 10);
        check("slow_idle",     busy[1], 0);
        wait_busy(1, 40, n);
        check("tick16_gap", n, 8);
        check("new_thr0", dp_thr[1], 50);
        check("new_cur0", dp_cur[1], 99);
        check("new_v0",   dp_v[1], 30);
        repeat (4) @(negedge clk);
        check("spk_thr50_v0", v0[1], 0);
        check("spk_thr50",    spike0[1], 1);
        in_cur0 = 8'd30;
        wait_idle(1, 20, n);
        check("slow_ovr", overrun[1], 0);

        // Overrun, TICK_DIV=8, ack 10 cycles after request
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        ack_dly[0] = 10;
        rst_n = 1'b1;
        wait_busy(0, 20, n);
        check("ovr_lat", n, 8);
        repeat (7) @(negedge clk);
        check("ovr_before", overrun[0], 0);
        @(negedge clk);
        check("ovr_set", overrun[0], 1);
        repeat (20) @(negedge clk);
        check("ovr_sticky", overrun[0], 1);
        cfg_write(3'd6, 8'h01);
        @(negedge clk);
        cfg_we = 1'b0;
        check("ovr_clr",   overrun[0], 0);
        check("clr_v0",    v0[0], 0);
        check("clr_v1",    v1[0], 0);
        repeat (3) @(negedge clk);
        check("ovr_reset_again", overrun[0], 1);
        repeat (3) @(negedge clk);
        check("ack_after_clr_v0", v0[0], 53);

        // Config write during a pending N1 request, ack 2 cycles after request
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        ack_dly[0] = 2;
        rst_n = 1'b1;
        wait_busy(0, 20, n);
        repeat (3) @(negedge clk);
        check("cfg_n1_sel", dp_sel[0], 1);
        check("cfg_n1_req", dp_req[0], 1);
        check("cfg_thr_a",  dp_thr[0], 100);
        cfg_write(3'd1, 8'd20);
        @(negedge clk);
        cfg_we = 1'b0;
        check("cfg_thr_b",  dp_thr[0], 100);
        check("cfg_req_b",  dp_req[0], 1);
        @(negedge clk);
        check("cfg_thr_c",  dp_thr[0], 100);
        @(negedge clk);
        check("cfg_v1",     v1[0], 10);
        check("cfg_idle",   busy[0], 0);
        wait_busy(0, 20, n);
        check("cfg_gap", n, 2);
        repeat (3) @(negedge clk);
        check("cfg_n1_sel2", dp_sel[0], 1);
        check("cfg_thr_new", dp_thr[0], 20);
        wait_idle(0, 20, n);

        // Asynchronous reset in the middle of a handshake
        ack_dly[0] = 10;
        wait_busy(0, 20, n);
        check("pre_rst_v0",  v0[0], 53);
        check("pre_rst_v1",  v1[0], 18);
        check("pre_rst_req", dp_req[0], 1);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_req",  dp_req[0], 0);
        check("arst_v0",   v0[0], 0);
        check("arst_v1",   v1[0], 0);
        check("arst_busy", busy[0], 0);
        check("arst_dpv",  dp_v[0], 0);
        @(negedge clk);
        @(negedge clk);
        ack_dly[0] = 0;
        rst_n = 1'b1;
        wait_busy(0, 20, n);
        check("rel_lat", n, 8);
        check("rel_req0", dp_req[0] && !dp_sel[0], 1);
        @(negedge clk);
        check("rel_v0", v0[0], 30);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/lif_step_scheduler.md
# lif_step_scheduler

Timestep scheduler for the dual leaky integrate-and-fire core. Generates the neuron timestep tick and time-multiplexes one shared membrane-update datapath between neuron 0 and neuron 1 over a req/ack handshake. Owns both membrane registers, the refractory counters and the per-neuron configuration registers. Sits between the pin-level wrapper (currents, config bus) and the LIF update datapath.

## Interface
- TICK_DIV, 16: clocks per timestep; legal range 4..65535.
- REFR_W, 4: refractory counter width.

- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ena  in  1  tick enable; low freezes the tick counter.
- in_cur0 / in_cur1  in  8  input currents (unsigned) for neuron 0 / 1.
- cfg_we  in  1  config write strobe, one write per cycle.
- cfg_addr  in  3  0 thr0, 1 thr1, 2 leak0, 3 leak1, 4 refr0, 5 refr1, 6 ctrl, 7 ignored.
- cfg_data  in  8  write data; leak uses [2:0], refr uses [REFR_W-1:0], ctrl bit0 = clear.
- dp_req  out  1  request to datapath.
- dp_sel  out  1  neuron served: 0 or 1.
- dp_v  out  8  membrane operand.
- dp_cur  out  8  current operand.
- dp_thr  out  8  threshold operand.
- dp_leak  out  3  leak shift operand.
- dp_ack  in  1  datapath result valid.
- dp_v_in  in  8  updated membrane.
- dp_spike  in  1  threshold crossed.
- v0 / v1  out  8  membrane registers.
- spike0 / spike1  out  1  one-cycle spike pulses.
- busy  out  1  FSM not IDLE.
- overrun  out  1  sticky: tick arrived while busy.

## Operation
- Reset values: thr0=thr1=100, leak0=leak1=2, refr0=refr1=3 (truncated to REFR_W), v0=v1=0, refractory counters 0, tick counter 0, all outputs 0, FSM IDLE.
- Tick counter: increments when ena=1, wraps at TICK_DIV-1; tick = (count==TICK_DIV-1 && ena).
- FSM states: IDLE, N0, N1.
- IDLE: on tick -> N0. Otherwise stay.
- Nn entry: if rcnt_n != 0: no request, rcnt_n decrements, v_n held 0, advance next cycle (N0->N1, N1->IDLE).
- Else: latch operands (v_n, in_cur_n, thr_n, leak_n) into dp_* registers, assert dp_req with dp_sel=n; hold all dp_* stable until dp_ack sampled high.
- On ack: dp_spike=1 -> v_n<=0, rcnt_n<=refr_n, spike_n pulses next cycle; dp_spike=0 -> v_n<=dp_v_in. Advance state; dp_req low the following cycle.
- dp_ack while dp_req=0: ignored. No arithmetic in this block; the datapath owns leak/integrate/compare.
- Tick while FSM not IDLE: tick dropped, overrun<=1 (sticky).
- ena=0 mid-timestep: in-flight handshake and remaining neuron still complete; no new ticks.
- Config writes take effect next cycle; operands already latched for an outstanding request are unaffected. Write to a refr register does not alter a running counter.
- ctrl write with bit0=1: v0, v1, both rcnt, overrun cleared next cycle; if FSM is busy it completes normally and its ack result overwrites the cleared v. Other ctrl bits ignored.

## Timing
- Tick cycle T -> dp_req high, dp_sel=0 at T+1.
- Same-cycle ack (combinational datapath): N0 at T+1, N1 at T+2, IDLE at T+3; v0 updated at T+2, v1 at T+3; spike0 high at T+2, spike1 at T+3.
- Each cycle of ack delay extends the respective state by one cycle.
- Refractory skip costs exactly one cycle per neuron, no dp_req pulse.
- busy high from T+1 until return to IDLE.
- Reset asserted any time: all outputs low asynchronously, including an active dp_req; no handshake completion after release.

## Test plan
- Integrate to spike: TICK_DIV=8, thr0=100, leak0=2, in_cur0=30, bench datapath v'=v-(v>>leak)+cur, spike if v'>=thr, ack same cycle -> v0 sequence 30,53,70,83,93 then spike0 on tick 6 with v0=0.
- Refractory: continue above with refr0=3 -> ticks 7-9 show no dp_req with dp_sel=0, v0=0; tick 10 gives v0=30; neuron 1 serviced every tick throughout.
- Slow datapath: ack delay 3 cycles -> dp_* operands stable while dp_req high, dp_req drops cycle after ack, overrun stays 0 at TICK_DIV=16.
- Overrun: ack delay 10 cycles, TICK_DIV=8 -> overrun=1 at second tick, stays 1; ctrl write 0x01 -> overrun=0.
- Config timing: write thr1=20 while N1 request pending -> pending request shows old dp_thr; next timestep dp_thr=20.
- Reset mid-handshake: rst_n low while dp_req=1 -> dp_req, v0, v1, busy go 0 immediately; after release first dp_req appears one cycle after tick, TICK_DIV cycles later.
